uart_receiver: RTL and testbench
================================

// Module: uart_receiver
// PURPOSE
//  Downstream counterpart of the btint UART transmitter. It deserialises the 1-wire link and rebuilds
//  the three 8-bit btint_a / btint_b element pairs, then presents them as a parallel word with a 1-cycle valid.
//  Line format, idle high: start(0), 8 data bits a[k],b[k],a[k+1],b[k+1],...,a[k+3],b[k+3], then stop(1), stop(1).
//  Each element takes 2 frames: low nibble (k=0) first, then high nibble (k=4).
//  Element order per word is [23:16], [15:8], [7:0]. One word is 6 frames of 11 bit-times each.
//  The link carries no overflow bits.
// PARAMETERS
//  CLKS_PER_BIT   1    clocks per bit-time; 1 matches the transmitter's one-bit-per-clock output.
//  SYNC_STAGES    2    flops in the rx input synchroniser (>=2).
//  IDLE_RESYNC    16   consecutive idle-high bit-times that force word realignment (frame counter to 0).
// PORTS
//  uart_receiver_clock           in   1   single clock, rising edge
//  uart_receiver_reset           in   1   asynchronous, active-low reset
//  uart_receiver_input           in   1   serial line from the transmitter
//  uart_receiver_output_btint_a  out  24  last complete word, a digits
//  uart_receiver_output_btint_b  out  24  last complete word, b digits
//  uart_receiver_output_valid    out  1   1-cycle pulse when both outputs update
//  uart_receiver_frame_error     out  1   1-cycle pulse on a stop bit sampled as 0
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - All outputs 0, state IDLE, frame counter 0, shadow registers 0.
//   - Synchroniser flops reset to 1 (idle).
//  Reset mid-frame: the partial word is discarded; reception restarts at the next start bit as frame 0.
//  Sampling: all decisions use the synchronised line (rx_s). Bit centre = CLKS_PER_BIT/2 clocks after
//   the start edge (0 when CLKS_PER_BIT=1). Subsequent samples occur every CLKS_PER_BIT clocks.
//  FSM states: IDLE, START, DATA, STOP1, STOP2, BREAK.
//   - IDLE: rx_s==0 -> START. Counts idle bit-times; reaching IDLE_RESYNC clears the frame counter (saturating).
//   - START: at centre, rx_s==1 -> IDLE (glitch, no error); else -> DATA, bit index 0.
//   - DATA: 8 samples. Bit n even -> a, n odd -> b.
//     Destination index = (2-frame/2)*8 + (frame%2)*4 + n/2 in the a_shadow or b_shadow register.
//   - STOP1: 1 -> STOP2. 0 -> frame_error pulse, frame counter 0, shadow discarded, -> BREAK.
//   - STOP2: same check as STOP1. On 1: if frame==5, copy the shadows to the outputs, pulse valid,
//     set frame to 0; else increment frame. -> IDLE.
//   - BREAK: waits for rx_s==1, then -> IDLE. A held-low line produces exactly one error pulse.
//  Back-to-back: IDLE detects a start bit in the clock immediately after the STOP2 sample.
//   No dead cycle is allowed, so continuous transmitter output is received with no lost frames.
//  Latency: valid asserts in the cycle after the STOP2 sample of frame 5.
//   That is SYNC_STAGES + CLKS_PER_BIT/2 + 1 clocks after that stop bit appears on the input.
//  Outputs hold between valid pulses. valid and frame_error are never high together.
//  Counters are sized to cover CLKS_PER_BIT-1, 7 and IDLE_RESYNC. They use no signed arithmetic.
// TESTING
//  1. Drive a=24'h123456, b=24'hA50FC3 as a continuous stream with CLKS_PER_BIT=1.
//     Required: outputs equal those values; valid pulses every 66 clocks; frame_error stays 0.
//  2. Corrupt STOP1 of frame 2 to 0.
//     Required: one frame_error pulse; no valid for that word; the next aligned word is received correctly
//     after an IDLE_RESYNC-long idle gap.
//  3. Set CLKS_PER_BIT=4 and inject a 1-clock low glitch on an idle line.
//     Required: no state change beyond START->IDLE; no error; no valid.
//  4. Assert reset for 1 cycle during frame 3 DATA.
//     Required: all outputs go to 0 immediately; the next 6 frames from a restarted transmitter yield one correct word.
//  5. Hold the line low for 40 bit-times, then return it to idle.
//     Required: exactly one frame_error pulse; FSM returns to IDLE; the following word is decoded correctly.
//  6. Send two words in succession, all-ones then all-zeros.
//     Required: valid twice, 66 clocks apart; outputs go 24'hFFFFFF, then 24'h000000.

Source files
------------

// File: rtl/uart_receiver_if.sv
// rtl/uart_receiver_if.sv - serial line and decoded word bundle for the btint UART receiver
//
// Purpose: groups the serial input and the decoded parallel outputs of uart_receiver.
// Signals:
//   uart_receiver_input           1   serial line, idle high (driven by the transmitter side)
//   uart_receiver_output_btint_a  24  last complete word, a digits
//   uart_receiver_output_btint_b  24  last complete word, b digits
//   uart_receiver_output_valid    1   1-cycle pulse when both words update
//   uart_receiver_frame_error     1   1-cycle pulse on a stop bit sampled low
// Modports:
//   master  transmitter/consumer side (drives the line, observes the word)
//   slave   receiver side (samples the line, drives the word)
interface uart_receiver_if;
  logic        uart_receiver_input;
  logic [23:0] uart_receiver_output_btint_a;
  logic [23:0] uart_receiver_output_btint_b;
  logic        uart_receiver_output_valid;
  logic        uart_receiver_frame_error;

  modport master (
    output uart_receiver_input,
    input  uart_receiver_output_btint_a,
    input  uart_receiver_output_btint_b,
    input  uart_receiver_output_valid,
    input  uart_receiver_frame_error
  );

  modport slave (
    input  uart_receiver_input,
    output uart_receiver_output_btint_a,
    output uart_receiver_output_btint_b,
    output uart_receiver_output_valid,
    output uart_receiver_frame_error
  );
endinterface

// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - btint UART receiver rebuilding 3-element a/b words from 6 serial frames
//
// Purpose: deserialises start/8 data/2 stop frames; data bits alternate a,b per nibble position.
//   Six frames (low nibble then high nibble of elements [23:16], [15:8], [7:0]) form one word.
// Ports:
//   uart_receiver_clock  in  rising-edge clock
//   uart_receiver_reset  in  asynchronous active-low reset
//   bus                  uart_receiver_if.slave (serial input, decoded word, valid, frame_error)
module uart_receiver #(
  parameter int CLKS_PER_BIT = 1,
  parameter int SYNC_STAGES  = 2,
  parameter int IDLE_RESYNC  = 16
) (
  input  logic           uart_receiver_clock,
  input  logic           uart_receiver_reset,
  uart_receiver_if.slave bus
);

  localparam int HALF    = CLKS_PER_BIT / 2;
  localparam int HALF_M1 = (HALF > 0) ? HALF - 1 : 0;
  localparam int CW      = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW      = $clog2(IDLE_RESYNC + 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP1, STOP2, BREAK} state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  state_t                 state, state_n;
  logic [CW-1:0]          clk_cnt, clk_cnt_n;
  logic [2:0]             bit_idx, bit_idx_n;
  logic [IW-1:0]          idle_cnt, idle_cnt_n;
  logic [2:0]             frame, frame_n;
  logic [23:0]            a_sh, a_sh_n, b_sh, b_sh_n;
  logic [23:0]            out_a, out_a_n, out_b, out_b_n;
  logic                   valid, valid_n, ferr, ferr_n;
  logic                   sample;
  logic [1:0]             elem;
  logic [4:0]             dest;

  assign rx_s = sync_q[SYNC_STAGES-1];

  // Synchroniser resets to the idle level so release never looks like a start bit.
  always_ff @(posedge uart_receiver_clock or negedge uart_receiver_reset) begin
    if (!uart_receiver_reset) sync_q <= '1;
    else                      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.uart_receiver_input};
  end

  always_ff @(posedge uart_receiver_clock or negedge uart_receiver_reset) begin
    if (!uart_receiver_reset) begin
      state    <= IDLE;
      clk_cnt  <= '0;
      bit_idx  <= '0;
      idle_cnt <= '0;
      frame    <= '0;
      a_sh     <= '0;
      b_sh     <= '0;
      out_a    <= '0;
      out_b    <= '0;
      valid    <= 1'b0;
      ferr     <= 1'b0;
    end else begin
      state    <= state_n;
      clk_cnt  <= clk_cnt_n;
      bit_idx  <= bit_idx_n;
      idle_cnt <= idle_cnt_n;
      frame    <= frame_n;
      a_sh     <= a_sh_n;
      b_sh     <= b_sh_n;
      out_a    <= out_a_n;
      out_b    <= out_b_n;
      valid    <= valid_n;
      ferr     <= ferr_n;
    end
  end

  // Bit-centre strobe for every state after START.
  assign sample = (clk_cnt == CW'(CLKS_PER_BIT - 1));
  // Element 0 of the frame sequence lands in [23:16]; frame[0] selects the nibble.
  assign elem   = 2'd2 - frame[2:1];
  assign dest   = {elem, frame[0], bit_idx[2:1]};

  always_comb begin
    state_n    = state;
    clk_cnt_n  = clk_cnt;
    bit_idx_n  = bit_idx;
    idle_cnt_n = idle_cnt;
    frame_n    = frame;
    a_sh_n     = a_sh;
    b_sh_n     = b_sh;
    out_a_n    = out_a;
    out_b_n    = out_b;
    valid_n    = 1'b0;
    ferr_n     = 1'b0;
    case (state)
      IDLE: begin
        if (idle_cnt == IW'(IDLE_RESYNC)) frame_n = '0;
        if (!rx_s) begin
          idle_cnt_n = '0;
          clk_cnt_n  = '0;
          bit_idx_n  = '0;
          // With a zero half-bit offset the detecting clock is already the start-bit
          // centre, so going straight to DATA keeps frames at exactly 11 bit-times.
          if (HALF == 0) state_n = DATA;
          else           state_n = START;
        end else if (sample) begin
          clk_cnt_n = '0;
          if (idle_cnt != IW'(IDLE_RESYNC)) idle_cnt_n = idle_cnt + 1'b1;
        end else begin
          clk_cnt_n = clk_cnt + 1'b1;
        end
      end
      START: begin
        if (clk_cnt == CW'(HALF_M1)) begin
          clk_cnt_n = '0;
          if (rx_s) state_n = IDLE;
          else      state_n = DATA;
        end else begin
          clk_cnt_n = clk_cnt + 1'b1;
        end
      end
      DATA: begin
        if (sample) begin
          clk_cnt_n = '0;
          if (bit_idx[0]) b_sh_n[dest] = rx_s;
          else            a_sh_n[dest] = rx_s;
          if (bit_idx == 3'd7) state_n = STOP1;
          else                 bit_idx_n = bit_idx + 3'd1;
        end else begin
          clk_cnt_n = clk_cnt + 1'b1;
        end
      end
      STOP1, STOP2: begin
        if (sample) begin
          clk_cnt_n = '0;
          if (!rx_s) begin
            ferr_n  = 1'b1;
            frame_n = '0;
            a_sh_n  = '0;
            b_sh_n  = '0;
            state_n = BREAK;
          end else if (state == STOP1) begin
            state_n = STOP2;
          end else begin
            idle_cnt_n = '0;
            state_n    = IDLE;
            if (frame == 3'd5) begin
              out_a_n = a_sh;
              out_b_n = b_sh;
              valid_n = 1'b1;
              frame_n = '0;
            end else begin
              frame_n = frame + 3'd1;
            end
          end
        end else begin
          clk_cnt_n = clk_cnt + 1'b1;
        end
      end
      BREAK: begin
        // A held-low line stays here so it reports only one error.
        if (rx_s) begin
          clk_cnt_n  = '0;
          idle_cnt_n = '0;
          state_n    = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.uart_receiver_output_btint_a = out_a;
  assign bus.uart_receiver_output_btint_b = out_b;
  assign bus.uart_receiver_output_valid   = valid;
  assign bus.uart_receiver_frame_error    = ferr;

endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - directed bench for uart_receiver at 1 and 4 clocks per bit
module tb_uart_receiver;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_receiver_if if1();
  uart_receiver_if if4();

  uart_receiver #(.CLKS_PER_BIT(1), .SYNC_STAGES(2), .IDLE_RESYNC(16)) dut1 (
    .uart_receiver_clock(clk),
    .uart_receiver_reset(rst_n),
    .bus(if1)
  );

  uart_receiver #(.CLKS_PER_BIT(4), .SYNC_STAGES(2), .IDLE_RESYNC(16)) dut4 (
    .uart_receiver_clock(clk),
    .uart_receiver_reset(rst_n),
    .bus(if4)
  );

  // Pulse monitors, sampled on the falling edge.
  int          v1 = 0, e1 = 0, both1 = 0, v4 = 0, e4 = 0;
  logic [23:0] ra1 [64];
  logic [23:0] rb1 [64];
  int          rc1 [64];
  logic [23:0] ra4 [8];
  logic [23:0] rb4 [8];

  always @(negedge clk) begin
    if (if1.uart_receiver_output_valid) begin
      ra1[v1 % 64] = if1.uart_receiver_output_btint_a;
      rb1[v1 % 64] = if1.uart_receiver_output_btint_b;
      rc1[v1 % 64] = cyc;
      v1++;
    end
    if (if1.uart_receiver_frame_error) e1++;
    if (if1.uart_receiver_output_valid && if1.uart_receiver_frame_error) both1++;
    if (if4.uart_receiver_output_valid) begin
      ra4[v4 % 8] = if4.uart_receiver_output_btint_a;
      rb4[v4 % 8] = if4.uart_receiver_output_btint_b;
      v4++;
    end
    if (if4.uart_receiver_frame_error) e4++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [10:0] frame_bits(input logic [23:0] a, input logic [23:0] b,
                                             input int f, input bit bad_stop1);
    logic [10:0] fb;
    int idx;
    fb[0] = 1'b0;
    for (int n = 0; n < 8; n++) begin
      idx = (2 - f / 2) * 8 + (f % 2) * 4 + n / 2;
      fb[1 + n] = (n % 2 == 1) ? b[idx] : a[idx];
    end
    fb[9]  = ~bad_stop1;
    fb[10] = 1'b1;
    return fb;
  endfunction

  task automatic drive(input int which, input logic v, input int clocks);
    repeat (clocks) begin
      @(negedge clk);
      if (which == 4) if4.uart_receiver_input = v;
      else            if1.uart_receiver_input = v;
    end
  endtask

  task automatic send_frame(input int which, input int cpb, input logic [23:0] a,
                            input logic [23:0] b, input int f, input bit bad);
    logic [10:0] fb;
    fb = frame_bits(a, b, f, bad);
    for (int i = 0; i < 11; i++) drive(which, fb[i], cpb);
  endtask

  task automatic send_word(input int which, input int cpb, input logic [23:0] a,
                           input logic [23:0] b, input int bad_frame);
    for (int f = 0; f < 6; f++) send_frame(which, cpb, a, b, f, f == bad_frame);
  endtask

  typedef struct {
    logic [23:0] a;
    logic [23:0] b;
  } vec_t;

  vec_t        tbl [5];
  int          base, eb, t0;
  logic [10:0] fb;

  initial begin
    tbl[0] = '{a: 24'h123456, b: 24'hA50FC3};
    tbl[1] = '{a: 24'hFFFFFF, b: 24'hFFFFFF};
    tbl[2] = '{a: 24'h000000, b: 24'h000000};
    tbl[3] = '{a: 24'h800001, b: 24'h7FFFFE};
    tbl[4] = '{a: 24'hC3A50F, b: 24'h0F0F0F};

    if1.uart_receiver_input = 1'b1;
    if4.uart_receiver_input = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_a",     {8'h0, if1.uart_receiver_output_btint_a}, 32'h0);
    check("reset_b",     {8'h0, if1.uart_receiver_output_btint_b}, 32'h0);
    check("reset_valid", {31'h0, if1.uart_receiver_output_valid}, 32'h0);
    check("reset_ferr",  {31'h0, if1.uart_receiver_frame_error}, 32'h0);
    check("reset_a4",    {8'h0, if4.uart_receiver_output_btint_a}, 32'h0);
    rst_n = 1'b1;
    drive(1, 1'b1, 4);

    // Continuous stream of table words; includes all-ones followed by all-zeros.
    base = v1;
    for (int i = 0; i < 5; i++) send_word(1, 1, tbl[i].a, tbl[i].b, -1);
    drive(1, 1'b1, 8);
    check("stream_count", v1 - base, 5);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("stream_a[%0d]", i), {8'h0, ra1[(base + i) % 64]}, {8'h0, tbl[i].a});
      check($sformatf("stream_b[%0d]", i), {8'h0, rb1[(base + i) % 64]}, {8'h0, tbl[i].b});
      if (i > 0)
        check($sformatf("stream_gap[%0d]", i), rc1[(base + i) % 64] - rc1[(base + i - 1) % 64], 66);
    end
    check("stream_hold_a", {8'h0, if1.uart_receiver_output_btint_a}, {8'h0, tbl[4].a});
    check("stream_ferr", e1, 0);

    // Latency from the last stop bit on the line to valid.
    base = v1;
    send_word(1, 1, 24'h13579B, 24'h2468AC, -1);
    t0 = cyc;
    drive(1, 1'b1, 8);
    check("lat_count", v1 - base, 1);
    check("lat_clocks", rc1[base % 64] - t0, 3);
    check("lat_a", {8'h0, ra1[base % 64]}, 32'h0013579B);

    // Corrupt STOP1 of frame 2, let the rest of the word go by, then idle to resync.
    base = v1; eb = e1;
    send_word(1, 1, 24'hDEAD00, 24'h00BEEF, 2);
    drive(1, 1'b1, 20);
    check("ferr_count", e1 - eb, 1);
    check("ferr_no_valid", v1 - base, 0);
    send_word(1, 1, 24'h0F1E2D, 24'h3C4B5A, -1);
    drive(1, 1'b1, 8);
    check("resync_count", v1 - base, 1);
    check("resync_a", {8'h0, ra1[base % 64]}, 32'h000F1E2D);
    check("resync_b", {8'h0, rb1[base % 64]}, 32'h003C4B5A);

    // 1-clock glitch on an idle line at 4 clocks per bit, then a real word.
    @(negedge clk); if4.uart_receiver_input = 1'b0;
    drive(4, 1'b1, 30);
    check("glitch_ferr", e4, 0);
    check("glitch_valid", v4, 0);
    send_word(4, 4, 24'h123456, 24'hA50FC3, -1);
    drive(4, 1'b1, 20);
    check("cpb4_count", v4, 1);
    check("cpb4_a", {8'h0, ra4[0]}, 32'h00123456);
    check("cpb4_b", {8'h0, rb4[0]}, 32'h00A50FC3);
    check("cpb4_ferr", e4, 0);

    // Reset in the middle of frame 3 data.
    for (int f = 0; f < 3; f++) send_frame(1, 1, 24'h654321, 24'h9ABCDE, f, 1'b0);
    fb = frame_bits(24'h654321, 24'h9ABCDE, 3, 1'b0);
    for (int i = 0; i < 5; i++) drive(1, fb[i], 1);
    @(negedge clk);
    if1.uart_receiver_input = 1'b1;
    rst_n = 1'b0;
    #1;
    check("midreset_a", {8'h0, if1.uart_receiver_output_btint_a}, 32'h0);
    check("midreset_b", {8'h0, if1.uart_receiver_output_btint_b}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 1'b1, 5);
    base = v1;
    send_word(1, 1, 24'h654321, 24'h9ABCDE, -1);
    drive(1, 1'b1, 8);
    check("restart_count", v1 - base, 1);
    check("restart_a", {8'h0, ra1[base % 64]}, 32'h00654321);
    check("restart_b", {8'h0, rb1[base % 64]}, 32'h009ABCDE);

    // Line held low for 40 bit-times.
    base = v1; eb = e1;
    drive(1, 1'b0, 40);
    drive(1, 1'b1, 20);
    check("break_ferr", e1 - eb, 1);
    check("break_no_valid", v1 - base, 0);
    send_word(1, 1, 24'hC0FFEE, 24'h1CEB00, -1);
    drive(1, 1'b1, 8);
    check("after_break_count", v1 - base, 1);
    check("after_break_a", {8'h0, ra1[base % 64]}, 32'h00C0FFEE);
    check("after_break_b", {8'h0, rb1[base % 64]}, 32'h001CEB00);
    check("valid_ferr_overlap", both1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
